// File: rtl/mmio_ctrl.sv
// MMIO controller for the 0x8000_00xx window: UART TX holding buffer, RX consume, cycle/instret counters.
// Loads return registered data one cycle later; the TX buffer drops stores when full and not draining.
module mmio_ctrl #(
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data_in,
  output logic        uart_tx_data_in_valid,
  input  logic        uart_tx_data_in_ready,
  input  logic [7:0]  uart_rx_data_out,
  input  logic        uart_rx_data_out_valid,
  output logic        uart_rx_data_out_ready
);

  localparam logic [31:0] A_CTRL = MMIO_BASE + 32'h00;
  localparam logic [31:0] A_RX   = MMIO_BASE + 32'h04;
  localparam logic [31:0] A_TX   = MMIO_BASE + 32'h08;
  localparam logic [31:0] A_CYC  = MMIO_BASE + 32'h10;
  localparam logic [31:0] A_INST = MMIO_BASE + 32'h14;
  localparam logic [31:0] A_CRST = MMIO_BASE + 32'h18;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic {TX_EMPTY, TX_FULL} tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 ovf_q, ovf_d;
  logic                 ovf_set;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] inst_q, inst_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 in_win;
  logic                 rd_en;
  logic                 tx_store;
  logic                 cnt_clr;
  logic                 unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign in_win   = (addr[31:8] == MMIO_BASE[31:8]);
  // A simultaneous store wins: the load side is suppressed entirely, including the RX consume.
  assign rd_en    = mem_re & ~mem_we & in_win;
  assign tx_store = mem_we & (addr == A_TX);
  assign cnt_clr  = mem_we & (addr == A_CRST);

  assign uart_rx_data_out_ready = ~rst & rd_en & (addr == A_RX) & uart_rx_data_out_valid;
  assign uart_tx_data_in_valid  = (tx_state_q == TX_FULL);
  assign uart_tx_data_in        = tx_data_q;
  assign rdata                  = rdata_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    ovf_set    = 1'b0;
    case (tx_state_q)
      TX_EMPTY: begin
        if (tx_store) begin
          tx_data_d  = wdata[7:0];
          tx_state_d = TX_FULL;
        end
      end
      TX_FULL: begin
        if (uart_tx_data_in_ready) begin
          if (tx_store) tx_data_d = wdata[7:0];
          else          tx_state_d = TX_EMPTY;
        end else if (tx_store) begin
          ovf_set = 1'b1;
        end
      end
      default: tx_state_d = TX_EMPTY;
    endcase
    // A new overflow in the same cycle as a control read must not be lost.
    if (ovf_set)                     ovf_d = 1'b1;
    else if (rd_en && addr == A_CTRL) ovf_d = 1'b0;
    else                             ovf_d = ovf_q;
  end

  always_comb begin
    cyc_d  = cnt_clr ? '0 : cyc_q + CNT_ONE;
    inst_d = cnt_clr ? '0 : (inst_retire ? inst_q + CNT_ONE : inst_q);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (addr)
        A_CTRL:  rdata_d = {29'b0, ovf_q, uart_rx_data_out_valid, (tx_state_q == TX_EMPTY)};
        A_RX:    rdata_d = uart_rx_data_out_valid ? {24'b0, uart_rx_data_out} : 32'b0;
        A_CYC:   rdata_d = 32'(cyc_q);
        A_INST:  rdata_d = 32'(inst_q);
        default: rdata_d = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_EMPTY;
      tx_data_q  <= 8'b0;
      ovf_q      <= 1'b0;
      cyc_q      <= '0;
      inst_q     <= '0;
      rdata_q    <= 32'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
      ovf_q      <= ovf_d;
      cyc_q      <= cyc_d;
      inst_q     <= inst_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl; a second instance with 8-bit counters exercises wrap and zero-extension.
module tb_mmio_ctrl;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic        inst_retire = 1'b0;
  logic        tx_rdy = 1'b0;
  logic [7:0]  rx_dat = '0;
  logic        rx_vld = 1'b0;

  logic [31:0] rdata, rdata8;
  logic [7:0]  tx_dat, tx_dat8;
  logic        tx_vld, tx_vld8;
  logic        rx_rdy, rx_rdy8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mmio_ctrl #(.MMIO_BASE(BASE), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mem_re(mem_re), .mem_we(mem_we),
    .inst_retire(inst_retire), .rdata(rdata), .uart_tx_data_in(tx_dat),
    .uart_tx_data_in_valid(tx_vld), .uart_tx_data_in_ready(tx_rdy),
    .uart_rx_data_out(rx_dat), .uart_rx_data_out_valid(rx_vld), .uart_rx_data_out_ready(rx_rdy)
  );

  mmio_ctrl #(.MMIO_BASE(BASE), .CNT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mem_re(mem_re), .mem_we(mem_we),
    .inst_retire(inst_retire), .rdata(rdata8), .uart_tx_data_in(tx_dat8),
    .uart_tx_data_in_valid(tx_vld8), .uart_tx_data_in_ready(tx_rdy),
    .uart_rx_data_out(rx_dat), .uart_rx_data_out_valid(rx_vld), .uart_rx_data_out_ready(rx_rdy8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a);
    mem_re = 1'b1; addr = a;
    tick();
    mem_re = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    mem_we = 1'b1; addr = a; wdata = d;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
    total++; if (tx_vld !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_vld); end
    total++; if (tx_dat !== 8'h0) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_dat); end
    total++; if (rx_rdy !== 1'b0) begin bad++; $display("FAIL reset_rx_ready got=%b exp=0", rx_rdy); end
  endtask

  task automatic test_counters;
    logic [9:0] pat;
    pat = 10'b0001001101;
    for (int i = 0; i < 10; i++) begin
      inst_retire = pat[i];
      tick();
    end
    inst_retire = 1'b0;
    do_load(BASE + 32'h10);
    total++; if (rdata !== 32'd10) begin bad++; $display("FAIL cycle_cnt got=%0d exp=10", rdata); end
    do_load(BASE + 32'h14);
    total++; if (rdata !== 32'd4) begin bad++; $display("FAIL inst_cnt got=%0d exp=4", rdata); end
  endtask

  task automatic test_tx_basic;
    tx_rdy = 1'b0;
    do_store(BASE + 32'h08, 32'hDEAD_BE41);
    total++; if (tx_vld !== 1'b1 || tx_dat !== 8'h41) begin bad++; $display("FAIL tx_hold1 got=%b/%h exp=1/41", tx_vld, tx_dat); end
    do_load(BASE);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL ctrl_full got=%h exp=%h", rdata, 32'h0); end
    total++; if (tx_vld !== 1'b1 || tx_dat !== 8'h41) begin bad++; $display("FAIL tx_hold2 got=%b/%h exp=1/41", tx_vld, tx_dat); end
    tick();
    total++; if (tx_vld !== 1'b1 || tx_dat !== 8'h41) begin bad++; $display("FAIL tx_hold3 got=%b/%h exp=1/41", tx_vld, tx_dat); end
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    total++; if (tx_vld !== 1'b0) begin bad++; $display("FAIL tx_after_hs got=%b exp=0", tx_vld); end
    do_load(BASE);
    total++; if (rdata !== 32'h1) begin bad++; $display("FAIL ctrl_empty got=%h exp=%h", rdata, 32'h1); end
  endtask

  task automatic test_tx_overflow;
    tx_rdy = 1'b0;
    do_store(BASE + 32'h08, 32'h41);
    do_store(BASE + 32'h08, 32'h42);
    total++; if (tx_vld !== 1'b1 || tx_dat !== 8'h41) begin bad++; $display("FAIL ovf_kept got=%b/%h exp=1/41", tx_vld, tx_dat); end
    do_load(BASE);
    total++; if (rdata !== 32'h4) begin bad++; $display("FAIL ovf_ctrl1 got=%h exp=%h", rdata, 32'h4); end
    do_load(BASE);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL ovf_ctrl2 got=%h exp=%h", rdata, 32'h0); end
  endtask

  task automatic test_back_to_back;
    tx_rdy = 1'b1;
    do_store(BASE + 32'h08, 32'h43);
    tx_rdy = 1'b0;
    total++; if (tx_vld !== 1'b1 || tx_dat !== 8'h43) begin bad++; $display("FAIL b2b_data got=%b/%h exp=1/43", tx_vld, tx_dat); end
    do_load(BASE);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL b2b_ctrl got=%h exp=%h", rdata, 32'h0); end
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    total++; if (tx_vld !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", tx_vld); end
  endtask

  task automatic test_rx;
    rx_vld = 1'b1; rx_dat = 8'h5A;
    mem_re = 1'b1; addr = BASE + 32'h04;
    #1;
    total++; if (rx_rdy !== 1'b1) begin bad++; $display("FAIL rx_ready_pulse got=%b exp=1", rx_rdy); end
    tick();
    mem_re = 1'b0;
    #1;
    total++; if (rx_rdy !== 1'b0) begin bad++; $display("FAIL rx_ready_drop got=%b exp=0", rx_rdy); end
    total++; if (rdata !== 32'h5A) begin bad++; $display("FAIL rx_data got=%h exp=%h", rdata, 32'h5A); end
    do_load(32'h0000_0010);
    total++; if (rdata !== 32'h5A) begin bad++; $display("FAIL outside_load got=%h exp=%h", rdata, 32'h5A); end
    mem_re = 1'b1; mem_we = 1'b1; addr = BASE + 32'h08; wdata = 32'h77;
    #1;
    total++; if (rx_rdy !== 1'b0) begin bad++; $display("FAIL re_we_ready got=%b exp=0", rx_rdy); end
    tick();
    mem_re = 1'b0; mem_we = 1'b0;
    total++; if (rdata !== 32'h5A) begin bad++; $display("FAIL re_we_rdata got=%h exp=%h", rdata, 32'h5A); end
    total++; if (tx_vld !== 1'b1 || tx_dat !== 8'h77) begin bad++; $display("FAIL re_we_store got=%b/%h exp=1/77", tx_vld, tx_dat); end
    tx_rdy = 1'b1; tick(); tx_rdy = 1'b0;
    rx_vld = 1'b0;
    mem_re = 1'b1; addr = BASE + 32'h04;
    #1;
    total++; if (rx_rdy !== 1'b0) begin bad++; $display("FAIL rx_empty_ready got=%b exp=0", rx_rdy); end
    tick();
    mem_re = 1'b0;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rx_empty_data got=%h exp=%h", rdata, 32'h0); end
  endtask

  task automatic test_unmapped;
    do_store(32'h0000_0008, 32'h55);
    total++; if (tx_vld !== 1'b0) begin bad++; $display("FAIL outside_store got=%b exp=0", tx_vld); end
    do_store(BASE + 32'h0C, 32'h55);
    total++; if (tx_vld !== 1'b0) begin bad++; $display("FAIL unmapped_store got=%b exp=0", tx_vld); end
    do_load(BASE + 32'h10);
    do_load(BASE + 32'h0C);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL unmapped_load got=%h exp=%h", rdata, 32'h0); end
  endtask

  task automatic test_counter_clear;
    inst_retire = 1'b1;
    do_store(BASE + 32'h18, 32'h0);
    inst_retire = 1'b0;
    do_load(BASE + 32'h10);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL clr_cycle got=%h exp=%h", rdata, 32'h0); end
    do_load(BASE + 32'h14);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL clr_inst got=%h exp=%h", rdata, 32'h0); end
  endtask

  task automatic test_wrap;
    do_store(BASE + 32'h18, 32'h0);
    for (int i = 0; i < 255; i++) tick();
    do_load(BASE + 32'h10);
    total++; if (rdata8 !== 32'h0000_00FF) begin bad++; $display("FAIL wrap8_pre got=%h exp=%h", rdata8, 32'hFF); end
    total++; if (rdata !== 32'd255) begin bad++; $display("FAIL wrap32_pre got=%0d exp=255", rdata); end
    do_load(BASE + 32'h10);
    total++; if (rdata8 !== 32'h0) begin bad++; $display("FAIL wrap8_post got=%h exp=%h", rdata8, 32'h0); end
    total++; if (rdata !== 32'd256) begin bad++; $display("FAIL wrap32_post got=%0d exp=256", rdata); end
  endtask

  task automatic test_reset_discard;
    tx_rdy = 1'b0;
    do_store(BASE + 32'h08, 32'h99);
    total++; if (tx_vld !== 1'b1) begin bad++; $display("FAIL pre_rst_valid got=%b exp=1", tx_vld); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (tx_vld !== 1'b0 || tx_dat !== 8'h0) begin bad++; $display("FAIL rst_discard got=%b/%h exp=0/00", tx_vld, tx_dat); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=%h", rdata, 32'h0); end
    tick();
    total++; if (tx_vld !== 1'b0) begin bad++; $display("FAIL rst_stays_empty got=%b exp=0", tx_vld); end
  endtask

  initial begin
    test_reset();
    test_counters();
    test_tx_basic();
    test_tx_overflow();
    test_back_to_back();
    test_rx();
    test_unmapped();
    test_counter_clear();
    test_wrap();
    test_reset_discard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
